// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud generator shared by the UART TX and RX paths.
// Produces an oversample tick, a TX bit tick and a re-phasable RX mid-bit strobe.
module uart_baud_gen_frac #(
    parameter int unsigned DIV_INT_W    = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DEFAULT_INT  = 325,
    parameter int unsigned DEFAULT_FRAC = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_INT_W-1:0] div_int,
    input  logic [FRAC_W-1:0]    div_frac,
    input  logic                 div_load,
    input  logic                 rx_resync,
    output logic                 TX_TICK,
    output logic                 RX_TICK,
    output logic                 RX_MID,
    output logic                 div_err
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_W = DIV_INT_W + 1;

    logic [DIV_INT_W-1:0] act_int;
    logic [FRAC_W-1:0]    act_frac;
    logic [FRAC_W-1:0]    acc;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     period;
    logic [OS_W-1:0]      tx_os;
    logic [OS_W-1:0]      rx_os;
    logic [FRAC_W:0]      sum;
    logic                 wrap;
    logic                 load_ok;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, act_frac};
        wrap    = (cnt == period - 1'b1);
        load_ok = div_load && (div_int >= DIV_INT_W'(2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int  <= DIV_INT_W'(DEFAULT_INT);
            act_frac <= FRAC_W'(DEFAULT_FRAC);
            period   <= CNT_W'(DEFAULT_INT);
            acc      <= '0;
            cnt      <= '0;
            tx_os    <= '0;
            rx_os    <= '0;
            TX_TICK  <= 1'b0;
            RX_TICK  <= 1'b0;
            RX_MID   <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            TX_TICK <= 1'b0;
            RX_TICK <= 1'b0;
            RX_MID  <= 1'b0;
            div_err <= 1'b0;
            if (load_ok) begin
                // A valid load restarts every phase and swallows any tick due now.
                act_int  <= div_int;
                act_frac <= div_frac;
                period   <= {1'b0, div_int};
                acc      <= '0;
                cnt      <= '0;
                tx_os    <= '0;
                rx_os    <= '0;
            end else begin
                if (div_load) begin
                    div_err <= 1'b1;
                end
                if (enable) begin
                    if (wrap) begin
                        cnt     <= '0;
                        acc     <= sum[FRAC_W-1:0];
                        period  <= {1'b0, act_int} + CNT_W'(sum[FRAC_W]);
                        RX_TICK <= 1'b1;
                        tx_os   <= tx_os + 1'b1;
                        TX_TICK <= (tx_os == OS_W'(OVERSAMPLE - 1));
                        // Resync beats the tick: phase restarts and mid strobe is dropped.
                        if (rx_resync) begin
                            rx_os <= '0;
                        end else begin
                            rx_os  <= rx_os + 1'b1;
                            RX_MID <= (rx_os == OS_W'(OVERSAMPLE / 2 - 1));
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (rx_resync) begin
                            rx_os <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: cadence, fractional pattern, resync,
// rejected loads, enable gating and asynchronous reset.
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        rx_resync = 1'b0;
    logic        TX_TICK, RX_TICK, RX_MID, div_err;

    int vectors = 0;
    int miscompares = 0;

    uart_baud_gen_frac #(
        .DIV_INT_W(16),
        .FRAC_W(4),
        .OVERSAMPLE(16),
        .DEFAULT_INT(325),
        .DEFAULT_FRAC(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .div_int(div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .rx_resync(rx_resync),
        .TX_TICK(TX_TICK),
        .RX_TICK(RX_TICK),
        .RX_MID(RX_MID),
        .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // sel: 0 RX_TICK, 1 TX_TICK, 2 RX_MID. n = edges until seen, -1 on timeout.
    task automatic wait_sig(input int sel, input int max, output int n);
        logic hit;
        n = -1;
        for (int k = 1; k <= max; k++) begin
            step();
            case (sel)
                0:       hit = RX_TICK;
                1:       hit = TX_TICK;
                default: hit = RX_MID;
            endcase
            if (hit) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    initial begin
        int n, sum, cnt, total;

        // Reset state, before any clock edge
        #1;
        chk("reset_outs", int'({TX_TICK, RX_TICK, RX_MID, div_err}), 0);
        step();
        step();
        reset = 1'b0;

        // 1: default divisor 325 + 8/16
        wait_sig(0, 400, n);
        chk("def_first", n, 325);
        chk("def_tx_tick1", int'(TX_TICK), 0);
        sum = 0;
        cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            wait_sig(0, 400, n);
            sum += n;
            chk($sformatf("def_int%0d", i), n, (i % 2 == 1) ? 325 : 326);
            if (i < 15 && TX_TICK) cnt++;
            if (i == 15) chk("def_tx_tick16", int'(TX_TICK), 1);
            if (i == 16) chk("def_tx_tick17", int'(TX_TICK), 0);
        end
        chk("def_sum16", sum, 5208);
        chk("def_tx_early", cnt, 0);

        // 2: 4/0
        load(4, 0);
        wait_sig(0, 20, n);
        chk("l40_first", n, 4);
        wait_sig(1, 100, n);
        chk("l40_tx_first", n + 4, 64);
        wait_sig(1, 100, n);
        chk("l40_tx_next", n, 64);
        wait_sig(0, 20, n);
        chk("l40_rx_after_tx", n, 4);

        // 3: 4/4, pattern 4,4,4,5
        load(4, 4);
        wait_sig(0, 20, n);
        chk("l44_first", n, 4);
        sum = 0;
        for (int i = 1; i <= 16; i++) begin
            wait_sig(0, 20, n);
            sum += n;
            chk($sformatf("l44_int%0d", i), n, (i % 4 == 0) ? 5 : 4);
        end
        chk("l44_sum16", sum, 68);

        // 4: resync between ticks with 4/0
        load(4, 0);
        step();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            wait_sig(0, 20, n);
            if (j < 8 && RX_MID) cnt++;
            if (j == 8) chk("rs_mid_8th", int'(RX_MID), 1);
        end
        chk("rs_mid_early", cnt, 0);
        wait_sig(2, 100, n);
        chk("rs_mid_period", n, 64);
        wait_sig(1, 100, n);
        wait_sig(1, 100, n);
        chk("rs_tx_period", n, 64);

        // Resync coincident with a tick
        wait_sig(0, 20, n);
        step();
        step();
        step();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        chk("rsc_tick", int'(RX_TICK), 1);
        chk("rsc_no_mid", int'(RX_MID), 0);
        cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            wait_sig(0, 20, n);
            if (j < 8 && RX_MID) cnt++;
            if (j == 8) chk("rsc_mid_8th", int'(RX_MID), 1);
        end
        chk("rsc_mid_early", cnt, 0);

        // 5: rejected loads
        wait_sig(0, 20, n);
        step();
        load(1, 3);
        chk("rej1_err", int'(div_err), 1);
        step();
        chk("rej1_err_clear", int'(div_err), 0);
        wait_sig(0, 20, n);
        chk("rej1_keep", n, 1);
        load(0, 0);
        chk("rej0_err", int'(div_err), 1);
        wait_sig(0, 20, n);
        chk("rej0_keep", n, 3);
        wait_sig(0, 20, n);
        chk("rej0_period", n, 4);

        // 6: enable low for 10 cycles mid-period
        step();
        step();
        enable = 1'b0;
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (RX_TICK || TX_TICK || RX_MID) cnt++;
        end
        enable = 1'b1;
        wait_sig(0, 20, n);
        total = 12 + n;
        chk("en_no_ticks", cnt, 0);
        chk("en_stretch", total, 14);

        // Asynchronous reset while RX_TICK is high
        wait_sig(0, 20, n);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_outs", int'({TX_TICK, RX_TICK, RX_MID, div_err}), 0);
        step();
        reset = 1'b0;
        wait_sig(0, 400, n);
        chk("post_rst_first", n, 325);
        wait_sig(0, 400, n);
        chk("post_rst_int1", n, 325);
        wait_sig(0, 400, n);
        chk("post_rst_int2", n, 326);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
